fipo_memory: RTL and testbench



---
 rtl/fipo_memory.sv | 48 ++++
 tb/tb_fipo_memory.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fipo_memory.sv
// fipo_memory: serial-in / parallel-out capture memory; define FIPO_WRAP_EN to keep loading past full instead of freezing.
module fipo_memory #(
  parameter int DEPTH = 312,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  output logic [DEPTH-1:0] parallel_out,
  output logic             end_writing,
  output logic             data_written
);
  logic [DEPTH-1:0] r_mem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_end;
  logic             r_done;
  logic             w_wr;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_last = r_cnt == CNT_W'(DEPTH - 1);
`ifdef FIPO_WRAP_EN
  assign w_wr      = enable;
  assign w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
`else
  // Once full the counter parks at DEPTH and all writes are refused.
  assign w_wr      = enable && !r_done;
  assign w_cnt_nxt = r_cnt + 1'b1;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_cnt  <= '0;
      r_end  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_end <= w_wr && w_last;
      if (w_wr) begin
        r_mem[r_cnt] <= serial_in;
        r_cnt        <= w_cnt_nxt;
        if (w_last) r_done <= 1'b1;
      end
    end
  end
  assign parallel_out = r_mem;
  assign end_writing  = r_end;
  assign data_written = r_done;
endmodule

// File: tb/tb_fipo_memory.sv
// tb_fipo_memory: directed loads of fipo_memory; images are queued at issue and checked by a monitor on each end_writing pulse.
module tb_fipo_memory;
  localparam int DEPTH = 312;
  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             serial_in;
  logic [DEPTH-1:0] parallel_out;
  logic             end_writing;
  logic             data_written;
  logic [DEPTH-1:0] q[$];
  logic [DEPTH-1:0] img;
  logic [DEPTH-1:0] snap;
  logic [DEPTH-1:0] part;
  int               n_chk = 0;
  int               n_err = 0;
  int               n_pulse = 0;
  int               n_push = 0;
  int               bad;

  fipo_memory #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .parallel_out(parallel_out), .end_writing(end_writing), .data_written(data_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DEPTH-1:0] act, input logic [DEPTH-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // end_writing is high for a whole cycle, so sampling on the falling edge sees it once per pulse.
  always @(negedge clk) begin
    if (end_writing) begin
      n_pulse++;
      chk("pulse_expected", DEPTH'(q.size() != 0), 1);
      if (q.size() != 0) begin
        chk("image", parallel_out, q.pop_front());
        chk("done_at_pulse", DEPTH'(data_written), 1);
      end
    end
  end

  task automatic drive(input logic en, input logic b);
    @(negedge clk);
    enable    = en;
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_img(input logic [DEPTH-1:0] e);
    q.push_back(e);
    n_push++;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({name, "_pout"}, parallel_out, 0);
    chk({name, "_end"}, DEPTH'(end_writing), 0);
    chk({name, "_done"}, DEPTH'(data_written), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; serial_in = 1'b0;
    do_reset("reset");
    // all zeros
    img = '0;
    expect_img(img);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0);
      if (parallel_out !== '0) bad = 1;
      if (i == DEPTH - 2) chk("zeros_not_done", DEPTH'(data_written), 0);
    end
    chk("zeros_stay_zero", DEPTH'(bad), 0);
    settle();
    chk("zeros_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    chk("zeros_done", DEPTH'(data_written), 1);
    repeat (3) drive(1'b0, 1'b0);
    chk("zeros_done_sticky", DEPTH'(data_written), 1);
    chk("zeros_end_low", DEPTH'(end_writing), 0);
    // all ones, partial fill visible from bit 0 upward
    do_reset("reset_ones");
    img = '1;
    expect_img(img);
    part = '0;
    for (int i = 0; i < 100; i++) part[i] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1);
      if (i == 99) chk("ones_partial", parallel_out, part);
    end
    settle();
    chk("ones_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
`ifdef FIPO_WRAP_EN
    img = '0;
    expect_img(img);
    part = '1;
    for (int i = 0; i < 20; i++) part[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0);
      if (i == 19) chk("wrap_overwrite", parallel_out, part);
    end
    settle();
    chk("wrap_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    chk("wrap_done", DEPTH'(data_written), 1);
`else
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
    settle();
    chk("ones_frozen", parallel_out, '1);
    chk("ones_no_repulse", DEPTH'(n_pulse), DEPTH'(n_push));
    chk("ones_done", DEPTH'(data_written), 1);
`endif
    // alternating, first bit 1
    do_reset("reset_alt");
    img = {156{2'b01}};
    expect_img(img);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, img[i]);
    settle();
    chk("alt_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    // random
    do_reset("reset_rand");
    for (int i = 0; i < DEPTH; i++) img[i] = 1'($urandom_range(0, 1));
    expect_img(img);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, img[i]);
    settle();
    chk("rand_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    chk("rand_done", DEPTH'(data_written), 1);
    // enable gating mid-load
    do_reset("reset_gate");
    for (int i = 0; i < DEPTH; i++) img[i] = (i % 3 == 0);
    expect_img(img);
    for (int i = 0; i < 150; i++) drive(1'b1, img[i]);
    snap = parallel_out;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0]);
      if (parallel_out !== snap || end_writing !== 1'b0) bad = 1;
    end
    chk("gate_hold", DEPTH'(bad), 0);
    for (int i = 150; i < DEPTH; i++) begin
      drive(1'b1, img[i]);
      if (i == DEPTH - 2) chk("gate_not_done", DEPTH'(data_written), 0);
    end
    settle();
    chk("gate_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    chk("gate_done", DEPTH'(data_written), 1);
    // asynchronous reset between edges, mid-load
    do_reset("reset_async");
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_pout", parallel_out, 0);
    chk("async_done", DEPTH'(data_written), 0);
    chk("async_end", DEPTH'(end_writing), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) img[i] = (i % 5 == 0);
    expect_img(img);
    drive(1'b1, img[0]);
    chk("restart_bit0", parallel_out, 1);
    for (int i = 1; i < DEPTH; i++) drive(1'b1, img[i]);
    settle();
    chk("restart_pulses", DEPTH'(n_pulse), DEPTH'(n_push));
    repeat (3) settle();
    chk("queue_drained", DEPTH'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
